// File: rtl/svpwm_leg_sequencer.sv
// svpwm_leg_sequencer: 12-sector SVPWM vector selector driving three half-bridges
// with per-leg dead-time, phase-loss clamp, minimum-pulse drop and gate polarity.
module svpwm_leg_sequencer #(
  parameter int unsigned TW              = 14,
  parameter int unsigned CW              = 16,
  parameter int unsigned DEAD            = 8,
  parameter int unsigned MIN_PULSE       = 4,
  parameter bit          GATE_ACTIVE_LOW = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sync_pulse,
  input  logic [3:0]    number_sector,
  input  logic [TW-1:0] T1,
  input  logic [TW-1:0] T2,
  input  logic [TW-1:0] T0,
  input  logic [CW-1:0] pwm_triangle,
  input  logic          enable,
  input  logic          change,
  input  logic [2:0]    broke_phase,
  output logic [2:0]    vector,
  output logic [2:0]    gate_h,
  output logic [2:0]    gate_l,
  output logic [2:0]    busy_dt
);

  localparam int unsigned SW  = CW + 1;
  localparam int unsigned DCW = 8;
  localparam logic [DCW-1:0] DEAD_LOAD = (DEAD == 0) ? '0 : DCW'(DEAD - 1);
  localparam logic [2:0] POL = GATE_ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {LEG_OFF, LEG_LOW, LEG_HIGH, LEG_DT} leg_state_e;

  logic [TW-1:0]  t1_q, t1_d, t2_q, t2_d, t0_q, t0_d;
  logic [3:0]     sector_q, sector_d;
  logic [2:0]     vector_q, vector_d;
  leg_state_e     leg_q [3];
  leg_state_e     leg_d [3];
  logic [DCW-1:0] cnt_q [3];
  logic [DCW-1:0] cnt_d [3];
  logic [2:0]     tgt_q, tgt_d;
  logic [2:0]     gate_h_q, gate_h_d, gate_l_q, gate_l_d, busy_q, busy_d;

  logic [2:0]     v1, v2, v3, want;
  logic [TW-1:0]  raw1, raw2, d1, d2, d3;
  logic [SW-1:0]  s1, s2, ramp;
  logic           inactive;

  function automatic logic valid_sector(input logic [3:0] s);
    return (s != 4'd0) && (s <= 4'd12);
  endfunction

  function automatic logic [8:0] vec_table(input logic [3:0] s);
    case (s)
      4'd1:    vec_table = 9'b100_110_111;
      4'd2:    vec_table = 9'b110_100_000;
      4'd3:    vec_table = 9'b110_010_000;
      4'd4:    vec_table = 9'b010_110_111;
      4'd5:    vec_table = 9'b010_011_111;
      4'd6:    vec_table = 9'b011_010_000;
      4'd7:    vec_table = 9'b011_001_000;
      4'd8:    vec_table = 9'b001_011_111;
      4'd9:    vec_table = 9'b001_101_111;
      4'd10:   vec_table = 9'b101_001_000;
      4'd11:   vec_table = 9'b101_100_000;
      4'd12:   vec_table = 9'b100_101_111;
      default: vec_table = 9'b000_000_000;
    endcase
  endfunction

  // Operand latch; a zero dwell with change set swaps to the pair partner sector.
  always_comb begin
    t1_d     = t1_q;
    t2_d     = t2_q;
    t0_d     = t0_q;
    sector_d = sector_q;
    if (sync_pulse) begin
      t1_d     = T1;
      t2_d     = T2;
      t0_d     = T0;
      sector_d = number_sector;
      if (change && (T1 == '0 || T2 == '0) && valid_sector(number_sector))
        sector_d = number_sector[0] ? number_sector + 4'd1 : number_sector - 4'd1;
    end
  end

  assign {v1, v2, v3} = vec_table(sector_q);

  // Even sectors traverse the two active vectors in reverse order.
  assign raw1 = sector_q[0] ? t1_q : t2_q;
  assign raw2 = sector_q[0] ? t2_q : t1_q;
  assign d1   = (32'(raw1) < MIN_PULSE) ? '0 : raw1;
  assign d2   = (32'(raw2) < MIN_PULSE) ? '0 : raw2;
  assign d3   = (32'(t0_q) < MIN_PULSE) ? '0 : t0_q;
  assign s1   = SW'(d1);
  assign s2   = SW'(d1) + SW'(d2);
  assign ramp = SW'(pwm_triangle);

  assign inactive = !enable || !valid_sector(sector_q) || (t1_q == '0 && t2_q == '0);

  always_comb begin
    vector_d = vector_q;
    if (inactive)                      vector_d = 3'b000;
    else if (ramp < s1 && d1 != '0)    vector_d = v1;
    else if (ramp < s2 && d2 != '0)    vector_d = v2;
    else if (ramp >= s2 && d3 != '0)   vector_d = v3;
  end

  assign want = vector_q & ~broke_phase;

  // Per-leg state machines; gate flops hold pin-level (polarity-applied) values.
  always_comb begin
    tgt_d    = tgt_q;
    gate_h_d = POL;
    gate_l_d = POL;
    busy_d   = 3'b000;
    for (int i = 0; i < 3; i++) begin
      leg_d[i] = leg_q[i];
      cnt_d[i] = cnt_q[i];
      if (inactive) begin
        leg_d[i] = LEG_OFF;
      end else begin
        case (leg_q[i])
          LEG_OFF, LEG_LOW, LEG_HIGH: begin
            if (leg_q[i] != (want[i] ? LEG_HIGH : LEG_LOW)) begin
              if (DEAD == 0) begin
                leg_d[i] = want[i] ? LEG_HIGH : LEG_LOW;
              end else begin
                leg_d[i] = LEG_DT;
                cnt_d[i] = DEAD_LOAD;
                tgt_d[i] = want[i];
              end
            end
          end
          LEG_DT: begin
            if (want[i] != tgt_q[i]) begin
              cnt_d[i] = DEAD_LOAD;
              tgt_d[i] = want[i];
            end else if (cnt_q[i] == '0) begin
              leg_d[i] = want[i] ? LEG_HIGH : LEG_LOW;
            end else begin
              cnt_d[i] = cnt_q[i] - DCW'(1);
            end
          end
          default: leg_d[i] = LEG_OFF;
        endcase
      end
      gate_h_d[i] = GATE_ACTIVE_LOW ^ (leg_d[i] == LEG_HIGH);
      gate_l_d[i] = GATE_ACTIVE_LOW ^ (leg_d[i] == LEG_LOW);
      busy_d[i]   = (leg_d[i] == LEG_DT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t1_q     <= '0;
      t2_q     <= '0;
      t0_q     <= '0;
      sector_q <= 4'd0;
      vector_q <= 3'b000;
      tgt_q    <= 3'b000;
      gate_h_q <= POL;
      gate_l_q <= POL;
      busy_q   <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        leg_q[i] <= LEG_OFF;
        cnt_q[i] <= '0;
      end
    end else begin
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      t0_q     <= t0_d;
      sector_q <= sector_d;
      vector_q <= vector_d;
      tgt_q    <= tgt_d;
      gate_h_q <= gate_h_d;
      gate_l_q <= gate_l_d;
      busy_q   <= busy_d;
      for (int i = 0; i < 3; i++) begin
        leg_q[i] <= leg_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign vector  = vector_q;
  assign gate_h  = gate_h_q;
  assign gate_l  = gate_l_q;
  assign busy_dt = busy_q;

endmodule

// File: tb/tb_svpwm_leg_sequencer.sv
// Directed bench: u0 runs with no dead-time and active-high gates,
// u8 with 8-cycle dead-time and active-low gate pins, both on shared inputs.
module tb_svpwm_leg_sequencer;

  logic        clk = 1'b0;
  logic        rst, sync_pulse, enable, change;
  logic [3:0]  number_sector;
  logic [13:0] T1, T2, T0;
  logic [15:0] pwm_triangle;
  logic [2:0]  broke_phase;
  logic [2:0]  vec0, gh0, gl0, bz0, vec8, gh8, gl8, bz8;
  logic [2:0]  ev, prev;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  svpwm_leg_sequencer #(.DEAD(0), .GATE_ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst(rst), .sync_pulse(sync_pulse), .number_sector(number_sector),
    .T1(T1), .T2(T2), .T0(T0), .pwm_triangle(pwm_triangle), .enable(enable),
    .change(change), .broke_phase(broke_phase),
    .vector(vec0), .gate_h(gh0), .gate_l(gl0), .busy_dt(bz0)
  );

  svpwm_leg_sequencer #(.DEAD(8), .GATE_ACTIVE_LOW(1'b1)) u8 (
    .clk(clk), .rst(rst), .sync_pulse(sync_pulse), .number_sector(number_sector),
    .T1(T1), .T2(T2), .T0(T0), .pwm_triangle(pwm_triangle), .enable(enable),
    .change(change), .broke_phase(broke_phase),
    .vector(vec8), .gate_h(gh8), .gate_l(gl8), .busy_dt(bz8)
  );

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Advance one clock, sample 1ns later, and check the shoot-through invariant.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("overlap0", gh0 & gl0, 3'b000);
    chk("overlap8", ~gh8 & ~gl8, 3'b000);
  endtask

  task automatic chk0(input string tag, input logic [2:0] h, input logic [2:0] l);
    chk({tag, ".u0h"}, gh0, h);
    chk({tag, ".u0l"}, gl0, l);
    chk({tag, ".u0b"}, bz0, 3'b000);
  endtask

  // u8 expectations are given at logic level; pins are inverted.
  task automatic chk8(input string tag, input logic [2:0] h, input logic [2:0] l,
                      input logic [2:0] b);
    chk({tag, ".u8h"}, gh8, ~h);
    chk({tag, ".u8l"}, gl8, ~l);
    chk({tag, ".u8b"}, bz8, b);
  endtask

  task automatic load(input logic [3:0] s, input logic c, input logic [13:0] a,
                      input logic [13:0] b, input logic [13:0] z);
    sync_pulse = 1'b1; number_sector = s; change = c; T1 = a; T2 = b; T0 = z;
    tick();
    sync_pulse = 1'b0; change = 1'b0;
  endtask

  task automatic pv(input string tag, input logic [15:0] p, input logic [2:0] e);
    pwm_triangle = p;
    tick();
    chk(tag, vec0, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sync_pulse = 1'b0; number_sector = 4'd0; T1 = '0; T2 = '0; T0 = '0;
    pwm_triangle = '0; enable = 1'b0; change = 1'b0; broke_phase = 3'b000;
    tick(); tick();
    chk("rst.vec0", vec0, 3'b000);
    chk("rst.vec8", vec8, 3'b000);
    chk0("rst", 3'b000, 3'b000);
    chk8("rst", 3'b000, 3'b000, 3'b000);

    // Sector 1 full ramp, no dead-time: gates follow vector one cycle later.
    rst = 1'b0; enable = 1'b1; pwm_triangle = '0;
    load(4'd1, 1'b0, 14'd100, 14'd50, 14'd200);
    prev = 3'b000;
    for (int r = 0; r < 350; r++) begin
      pwm_triangle = 16'(r);
      tick();
      ev = (r < 100) ? 3'b100 : ((r < 150) ? 3'b110 : 3'b111);
      chk("ramp.vec", vec0, ev);
      chk0("ramp.gate", prev, ~prev);
      prev = ev;
    end

    // Settle on 100, then 100 -> 110: leg B gets 8 dead cycles in u8.
    pwm_triangle = 16'd0;
    repeat (20) tick();
    chk("settle.vec", vec0, 3'b100);
    chk0("settle", 3'b100, 3'b011);
    chk8("settle", 3'b100, 3'b011, 3'b000);
    pwm_triangle = 16'd120;
    tick();
    chk("dt.vec8", vec8, 3'b110);
    chk8("dt.pre", 3'b100, 3'b011, 3'b000);
    chk0("dt.pre", 3'b100, 3'b011);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk8("dt.in", 3'b100, 3'b001, 3'b010);
    end
    chk0("dt.u0", 3'b110, 3'b001);
    tick();
    chk8("dt.out", 3'b110, 3'b001, 3'b000);
    repeat (3) tick();

    // Target toggles back inside dead-time: count restarts.
    pwm_triangle = 16'd0;
    tick();
    chk8("tog.pre", 3'b110, 3'b001, 3'b000);
    tick();
    chk8("tog.dt1", 3'b100, 3'b001, 3'b010);
    pwm_triangle = 16'd120;
    tick();
    chk8("tog.dt2", 3'b100, 3'b001, 3'b010);
    for (int k = 3; k <= 10; k++) begin
      tick();
      chk8("tog.dt", 3'b100, 3'b001, 3'b010);
    end
    tick();
    chk8("tog.out", 3'b110, 3'b001, 3'b000);
    repeat (2) tick();

    // Phase-loss clamp on leg A.
    broke_phase = 3'b100;
    tick();
    chk0("brk.a", 3'b010, 3'b101);
    chk8("brk.a", 3'b010, 3'b001, 3'b100);
    repeat (9) tick();
    chk8("brk.a2", 3'b010, 3'b101, 3'b000);
    pwm_triangle = 16'd200;
    tick(); tick();
    chk("brk.vec", vec0, 3'b111);
    chk0("brk.b", 3'b011, 3'b100);
    repeat (12) tick();
    chk8("brk.b", 3'b011, 3'b100, 3'b000);
    pwm_triangle = 16'd0;
    tick(); tick();
    chk("brk.vec2", vec0, 3'b100);
    chk0("brk.c", 3'b000, 3'b111);
    repeat (12) tick();
    chk8("brk.c", 3'b000, 3'b111, 3'b000);
    broke_phase = 3'b000;

    // Sector 3 with change and T1=0 becomes sector 4: D=(80,0,100).
    load(4'd3, 1'b1, 14'd0, 14'd80, 14'd100);
    for (int r = 0; r < 200; r++) begin
      pwm_triangle = 16'(r);
      tick();
      ev = (r < 80) ? 3'b010 : 3'b111;
      chk("chg.vec", vec0, ev);
    end

    // change set but both dwells nonzero: no swap, sector 3 = 110/010/000.
    load(4'd3, 1'b1, 14'd30, 14'd40, 14'd50);
    pv("s3.a", 16'd10, 3'b110);
    pv("s3.b", 16'd50, 3'b010);
    pv("s3.c", 16'd80, 3'b000);

    // Sector 12 with change and T2=0 becomes sector 11: D=(40,0,30).
    load(4'd12, 1'b1, 14'd40, 14'd0, 14'd30);
    pv("s11.a", 16'd39, 3'b101);
    pv("s11.b", 16'd40, 3'b000);

    // Sector 12 plain: D=(20,10,30), vectors 100/101/111.
    load(4'd12, 1'b0, 14'd10, 14'd20, 14'd30);
    pv("s12.a", 16'd19, 3'b100);
    pv("s12.b", 16'd20, 3'b101);
    pv("s12.c", 16'd29, 3'b101);
    pv("s12.d", 16'd30, 3'b111);

    // Minimum pulse: T1=3 dropped, T1=4 kept.
    load(4'd1, 1'b0, 14'd3, 14'd50, 14'd100);
    pv("mp3.a", 16'd0, 3'b110);
    pv("mp3.b", 16'd49, 3'b110);
    pv("mp3.c", 16'd50, 3'b111);
    load(4'd1, 1'b0, 14'd4, 14'd50, 14'd100);
    pv("mp4.a", 16'd3, 3'b100);
    pv("mp4.b", 16'd4, 3'b110);
    pv("mp4.c", 16'd53, 3'b110);
    pv("mp4.d", 16'd54, 3'b111);

    // T0 below minimum: past S2 the vector holds its previous value.
    load(4'd1, 1'b0, 14'd10, 14'd10, 14'd2);
    pv("hold.a", 16'd5, 3'b100);
    pv("hold.b", 16'd15, 3'b110);
    pv("hold.c", 16'd25, 3'b110);
    pv("hold.d", 16'd5, 3'b100);
    pv("hold.e", 16'd25, 3'b100);

    // Inactive: invalid sector, then zero T1/T2.
    load(4'd13, 1'b0, 14'd10, 14'd20, 14'd30);
    tick();
    chk("inv13.vec", vec0, 3'b000);
    chk0("inv13", 3'b000, 3'b000);
    chk8("inv13", 3'b000, 3'b000, 3'b000);
    load(4'd2, 1'b0, 14'd10, 14'd20, 14'd30);
    tick();
    chk("s2.vec", vec0, 3'b100);
    load(4'd1, 1'b0, 14'd0, 14'd0, 14'd30);
    tick();
    chk("zero.vec", vec0, 3'b000);

    // Enable drop mid-segment, then reset mid-DT with a coincident sync_pulse.
    load(4'd1, 1'b0, 14'd100, 14'd50, 14'd200);
    pwm_triangle = 16'd0;
    repeat (20) tick();
    chk8("en.settle", 3'b100, 3'b011, 3'b000);
    pwm_triangle = 16'd120;
    tick(); tick();
    chk8("en.dt", 3'b100, 3'b001, 3'b010);
    enable = 1'b0;
    tick();
    chk("en.vec0", vec0, 3'b000);
    chk("en.vec8", vec8, 3'b000);
    chk0("en.off", 3'b000, 3'b000);
    chk8("en.off", 3'b000, 3'b000, 3'b000);
    enable = 1'b1;
    tick();
    chk("en.re", vec0, 3'b110);
    chk8("en.re", 3'b000, 3'b000, 3'b111);
    tick(); tick();
    rst = 1'b1; sync_pulse = 1'b1; number_sector = 4'd5; T1 = 14'd10; T2 = 14'd10;
    tick();
    chk("rst2.vec0", vec0, 3'b000);
    chk("rst2.vec8", vec8, 3'b000);
    chk0("rst2", 3'b000, 3'b000);
    chk8("rst2", 3'b000, 3'b000, 3'b000);
    rst = 1'b0; sync_pulse = 1'b0;
    tick(); tick();
    chk("rstwins.vec", vec0, 3'b000);
    chk8("rstwins", 3'b000, 3'b000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
